// File: rtl/cpu_branch_serial_unit_pkg.sv
// Shared definitions for the serial branch resolver: funct3 codes, FSM states, op helpers.
package cpu_branch_pkg;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    // Signed compares are turned into unsigned ones by flipping the operand MSBs.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == BR_LT) || (op == BR_GE);
    endfunction

    // funct3 010 and 011 are not branch encodings.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op != 3'b010) && (op != 3'b011);
    endfunction

    // Map the final {eq, lt} scan result onto the branch condition.
    function automatic logic eval_taken(input logic [2:0] op, input logic eq, input logic lt);
        logic t;
        t = 1'b0;
        case (op)
            BR_EQ:          t = eq;
            BR_NE:          t = !eq;
            BR_LT, BR_LTU:  t = lt;
            BR_GE, BR_GEU:  t = !lt;
            default:        t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cpu_branch_serial_unit_if.sv
// Request/response handshake bundle between the execute stage and the branch resolver.
interface cpu_branch_serial_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_taken;
    logic             resp_illegal;
    logic             busy;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_taken, resp_illegal, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_taken, resp_illegal, busy
    );
endinterface

// File: rtl/cpu_branch_slice_cmp.sv
// Combinational unsigned compare of one CHUNK-bit operand slice.
module cpu_branch_slice_cmp #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             eq,
    output logic             lt
);
    assign eq = (a == b);
    assign lt = (a < b);
endmodule

// File: rtl/cpu_branch_serial_unit.sv
// Multi-cycle branch condition resolver: scans operands MSB-first, one CHUNK slice per cycle,
// stopping at the first differing slice.
// Optional feature: define BRANCH_STATS_EN to add response/taken counters (stat_total, stat_taken).
module cpu_branch_serial_unit
    import cpu_branch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    cpu_branch_serial_unit_if.slave  bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]              stat_total,
    output logic [31:0]              stat_taken
`endif
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDXW-1:0]  idx;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic             slice_eq;
    logic             slice_lt;

    // Select the slice currently under inspection.
    always_comb begin
        slice_a = CHUNK'(a_q >> (32'(idx) * CHUNK));
        slice_b = CHUNK'(b_q >> (32'(idx) * CHUNK));
    end

    cpu_branch_slice_cmp #(.CHUNK(CHUNK)) u_slice_cmp (
        .a  (slice_a),
        .b  (slice_b),
        .eq (slice_eq),
        .lt (slice_lt)
    );

    // Control FSM with registered handshake outputs and operand latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            op_q             <= BR_EQ;
            a_q              <= '0;
            b_q              <= '0;
            idx              <= '0;
            bus.req_ready    <= 1'b1;
            bus.resp_valid   <= 1'b0;
            bus.resp_taken   <= 1'b0;
            bus.resp_illegal <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        op_q          <= bus.req_op;
                        a_q           <= bus.req_a ^ (is_signed_op(bus.req_op) ? MSB_MASK : '0);
                        b_q           <= bus.req_b ^ (is_signed_op(bus.req_op) ? MSB_MASK : '0);
                        idx           <= IDX_TOP;
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (!is_legal_op(bus.req_op)) begin
                            state            <= RESP;
                            bus.resp_valid   <= 1'b1;
                            bus.resp_taken   <= 1'b0;
                            bus.resp_illegal <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    // A differing slice decides the compare; all-equal resolves at slice 0.
                    if (!slice_eq || idx == '0) begin
                        state            <= RESP;
                        bus.resp_valid   <= 1'b1;
                        bus.resp_taken   <= eval_taken(op_q, slice_eq, slice_lt);
                        bus.resp_illegal <= 1'b0;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        bus.busy       <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    bus.busy       <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // Count delivered responses and how many of them were taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_total <= '0;
            stat_taken <= '0;
        end else if (bus.resp_valid && bus.resp_ready) begin
            stat_total <= stat_total + 32'd1;
            stat_taken <= stat_taken + 32'(bus.resp_taken);
        end
    end
`endif

endmodule

// File: tb/tb_cpu_branch_serial_unit.sv
// Self-checking bench for cpu_branch_serial_unit (WIDTH=32, CHUNK=8), scoreboard driven.
module tb_cpu_branch_serial_unit;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CHUNK  = 8;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;

    typedef struct {
        logic taken;
        logic illegal;
        int   lat;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_total;
    int   exp_taken;
    exp_t sb[$];

    cpu_branch_serial_unit_if #(.WIDTH(WIDTH)) bus ();

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_total;
    logic [31:0] stat_taken;
`endif

    cpu_branch_serial_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef BRANCH_STATS_EN
        ,
        .stat_total (stat_total),
        .stat_taken (stat_taken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: branch semantics plus MSB-first scan length.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   k;
        e.illegal = (op == 3'b010) || (op == 3'b011);
        k = 0;
        for (int i = NCHUNK - 1; i >= 0; i--) begin
            k++;
            if (a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK]) break;
        end
        e.lat = e.illegal ? 0 : k;
        case (op)
            3'b000:  e.taken = (a == b);
            3'b001:  e.taken = (a != b);
            3'b100:  e.taken = ($signed(a) < $signed(b));
            3'b101:  e.taken = ($signed(a) >= $signed(b));
            3'b110:  e.taken = (a < b);
            3'b111:  e.taken = (a >= b);
            default: e.taken = 1'b0;
        endcase
        return e;
    endfunction

    // Issue one request, check latency/result, optionally back-pressure, then accept.
    task automatic run_req(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int hold);
        exp_t e;
        int   lat;
        logic t0;
        logic i0;
        sb.push_back(model(op, a, b));
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_a     = ~a;
        bus.req_b     = b ^ 32'h5a5a_a5a5;
        bus.req_op    = 3'b001;
        lat = 0;
        while (!bus.resp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("FAIL %s latency got %0d expected %0d", name, lat, e.lat);
        end
        checks++;
        if (bus.resp_taken !== e.taken || bus.resp_illegal !== e.illegal) begin
            errors++;
            $display("FAIL %s result got taken=%b illegal=%b expected taken=%b illegal=%b",
                     name, bus.resp_taken, bus.resp_illegal, e.taken, e.illegal);
        end
        checks++;
        if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s in-flight got req_ready=%b busy=%b expected 0 1", name, bus.req_ready, bus.busy);
        end
        t0 = bus.resp_taken;
        i0 = bus.resp_illegal;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_taken !== e.taken || bus.resp_illegal !== e.illegal
                || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold got v=%b t=%b i=%b rdy=%b expected 1 %b %b 0",
                         name, bus.resp_valid, bus.resp_taken, bus.resp_illegal, bus.req_ready,
                         e.taken, e.illegal);
            end
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        exp_total++;
        if (e.taken) exp_taken++;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0
            || bus.resp_taken !== t0 || bus.resp_illegal !== i0) begin
            errors++;
            $display("FAIL %s release got v=%b rdy=%b busy=%b t=%b i=%b expected 0 1 0 %b %b",
                     name, bus.resp_valid, bus.req_ready, bus.busy, bus.resp_taken, bus.resp_illegal, t0, i0);
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 3'b000;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_taken !== 1'b0
            || bus.resp_illegal !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got rdy=%b v=%b t=%b i=%b busy=%b expected 1 0 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_taken, bus.resp_illegal, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_req("beq_equal",   3'b000, 32'h1234_5678, 32'h1234_5678, 0);
        run_req("blt_neg",     3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_req("bltu_same",   3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_req("bge_min",     3'b101, 32'h8000_0000, 32'h8000_0000, 0);
        run_req("bne_slice1",  3'b001, 32'h0000_0100, 32'h0000_0000, 0);
        run_req("bgeu_lsb",    3'b111, 32'h0000_0001, 32'h0000_0002, 0);
    endtask

    task automatic test_illegal_backpressure();
        run_req("illegal_010", 3'b010, 32'h0000_0005, 32'h0000_0005, 10);
        run_req("illegal_011", 3'b011, 32'hDEAD_BEEF, 32'h0000_0000, 2);
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b000;
        bus.req_a     = 32'hCAFE_F00D;
        bus.req_b     = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_scan got busy=%b rdy=%b v=%b expected 0 1 0",
                     bus.busy, bus.req_ready, bus.resp_valid);
        end
        exp_total = 0;
        exp_taken = 0;
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_discard got %0d resp_valid cycles expected 0", seen);
        end
        run_req("beq_after_rst", 3'b000, 32'h0000_00AA, 32'h0000_00AA, 0);
    endtask

    task automatic test_random();
        logic [2:0]  ops[8];
        logic [31:0] a;
        logic [31:0] b;
        ops = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            b = a;
            case ($urandom_range(0, 2))
                0: b = a;
                1: b[$urandom_range(0, 31)] = ~a[$urandom_range(0, 31)];
                default: b = $urandom;
            endcase
            run_req("random", ops[$urandom_range(0, 7)], a, b, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_stats();
`ifdef BRANCH_STATS_EN
        #1;
        checks++;
        if (stat_total !== 32'(exp_total) || stat_taken !== 32'(exp_taken)) begin
            errors++;
            $display("FAIL stats got total=%0d taken=%0d expected %0d %0d",
                     stat_total, stat_taken, exp_total, exp_taken);
        end
`endif
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_total = 0;
        exp_taken = 0;
        test_reset();
        test_directed();
        test_illegal_backpressure();
        test_reset_mid_scan();
        test_random();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
